serial_sub_ctrl: RTL and testbench

//   Bit-serial WIDTH-bit subtractor built around the existing one-bit full subtractor
//   Lab2_full_sub (ports X,Y,Z -> B,D).
//   - Upstream of the cell: presents operand bits X,Y and stored borrow Z each cycle.
//   - Downstream of the cell: registers borrow B and shifts difference bit D into the result.
//   - Result: diff = (a - b) mod 2^WIDTH; borrow_out = (a < b), unsigned compare.
//   - Sits between a register/test source and any consumer of the difference; start/done handshake.

---
 rtl/sub_pkg.sv | 11 +
 rtl/Lab2_full_sub.sv | 14 +
 rtl/serial_sub_ctrl.sv | 97 +++++++++
 tb/tb_serial_sub_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/sub_pkg.sv
// Shared definitions for the bit-serial subtractor controller.
// The state encoding is fixed so debug probes and scan dumps read the same values everywhere.
package sub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/Lab2_full_sub.sv
// One-bit full subtractor cell: computes X - Y - Z.
// D is the difference bit and B is the borrow out of this bit position.
module Lab2_full_sub (
  input  logic X,
  input  logic Y,
  input  logic Z,
  output logic B,
  output logic D
);

  assign D = X ^ Y ^ Z;
  assign B = (~X & (Y | Z)) | (Y & Z);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial WIDTH-bit subtractor: one full-subtractor cell, LSB first, one bit per cycle,
// with a start/done handshake. Result diff = (a - b) mod 2^WIDTH, borrow_out = (a < b).
//
// state    | meaning
// ST_IDLE  | waiting for start; diff/borrow_out hold the last result
// ST_SHIFT | one operand bit pair per cycle through the cell
// ST_DONE  | done pulse, result valid; returns to idle next edge
module serial_sub_ctrl
  import sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] res;
  logic             brw;
  logic [CNT_W-1:0] cnt;
  logic             cell_b;
  logic             cell_d;

  Lab2_full_sub u_cell (
    .X (sa[0]),
    .Y (sb[0]),
    .Z (brw),
    .B (cell_b),
    .D (cell_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      sa         <= '0;
      sb         <= '0;
      res        <= '0;
      brw        <= 1'b0;
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            sa    <= a;
            sb    <= b;
            brw   <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          brw <= cell_b;
          sa  <= {1'b0, sa[WIDTH-1:1]};
          sb  <= {1'b0, sb[WIDTH-1:1]};
          res <= {cell_d, res[WIDTH-1:1]};
          // Last bit: publish the result straight from the cell rather than waiting a cycle for res.
          if (cnt == CNT_LAST) begin
            diff       <= {cell_d, res[WIDTH-1:1]};
            borrow_out <= cell_b;
            done       <= 1'b1;
            state      <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Scoreboard bench for serial_sub_ctrl at WIDTH=8 (directed + random) and WIDTH=4 (exhaustive).
// Expected results come from plain modular arithmetic on the operands.
module tb_serial_sub_ctrl;

  typedef struct {
    logic [7:0]  d;
    logic        br;
    int unsigned n;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8, start4;
  logic [7:0] a8, b8;
  logic [3:0] a4, b4;
  logic       busy8, done8, borrow8;
  logic       busy4, done4, borrow4;
  logic [7:0] diff8;
  logic [3:0] diff4;

  int          checks   = 0;
  int          failures = 0;
  int unsigned cyc      = 0;
  bit          end_req  = 1'b0;

  exp_t q8[$];
  exp_t q4[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_sub_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow_out(borrow8)
  );

  serial_sub_ctrl #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .diff(diff4), .borrow_out(borrow4)
  );

  function automatic void chk(input string name, input bit ok, input string msg);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: %s", name, msg);
    end
  endfunction

  // ---------------- monitor / scoreboard ----------------
  logic       rst_at_edge;
  logic [7:0] hold8;
  logic       hb8;
  logic [3:0] hold4;
  logic       hb4;
  logic       prev_done8, prev_done4;
  int         run8, run4;
  exp_t       e;

  always @(posedge clk) begin
    rst_at_edge = rst;
    #1;
    if (rst_at_edge) begin
      chk("reset8", busy8 == 0 && done8 == 0 && diff8 == 0 && borrow8 == 0,
          $sformatf("busy=%0b done=%0b diff=%h borrow=%0b, required all zero", busy8, done8, diff8, borrow8));
      chk("reset4", busy4 == 0 && done4 == 0 && diff4 == 0 && borrow4 == 0,
          $sformatf("busy=%0b done=%0b diff=%h borrow=%0b, required all zero", busy4, done4, diff4, borrow4));
      hold8 = '0; hb8 = 1'b0; run8 = 0;
      hold4 = '0; hb4 = 1'b0; run4 = 0;
    end else begin
      if (done8) begin
        chk("done_pulse8", !prev_done8, "done high two cycles in a row, required one");
        if (q8.size() == 0) begin
          chk("unexpected_done8", 1'b0, $sformatf("done with diff=%h, required no done", diff8));
        end else begin
          e = q8.pop_front();
          chk("diff8", diff8 == e.d, $sformatf("got %h required %h", diff8, e.d));
          chk("borrow8", borrow8 == e.br, $sformatf("got %0b required %0b", borrow8, e.br));
          chk("latency8", (cyc - e.n) == 9, $sformatf("got %0d edges required 9", cyc - e.n));
          hold8 = e.d; hb8 = e.br;
        end
      end else begin
        chk("hold8", diff8 == hold8 && borrow8 == hb8,
            $sformatf("got %h/%0b required %h/%0b", diff8, borrow8, hold8, hb8));
      end
      if (busy8) run8++;
      else if (run8 != 0) begin
        chk("busy_len8", run8 == 9, $sformatf("busy %0d cycles required 9", run8));
        run8 = 0;
      end

      if (done4) begin
        chk("done_pulse4", !prev_done4, "done high two cycles in a row, required one");
        if (q4.size() == 0) begin
          chk("unexpected_done4", 1'b0, $sformatf("done with diff=%h, required no done", diff4));
        end else begin
          e = q4.pop_front();
          chk("diff4", diff4 == e.d[3:0], $sformatf("got %h required %h", diff4, e.d[3:0]));
          chk("borrow4", borrow4 == e.br, $sformatf("got %0b required %0b", borrow4, e.br));
          chk("latency4", (cyc - e.n) == 5, $sformatf("got %0d edges required 5", cyc - e.n));
          hold4 = e.d[3:0]; hb4 = e.br;
        end
      end else begin
        chk("hold4", diff4 == hold4 && borrow4 == hb4,
            $sformatf("got %h/%0b required %h/%0b", diff4, borrow4, hold4, hb4));
      end
      if (busy4) run4++;
      else if (run4 != 0) begin
        chk("busy_len4", run4 == 5, $sformatf("busy %0d cycles required 5", run4));
        run4 = 0;
      end
    end
    prev_done8 = done8;
    prev_done4 = done4;

    if (end_req) begin
      chk("drain8", q8.size() == 0, $sformatf("%0d results outstanding, required 0", q8.size()));
      chk("drain4", q4.size() == 0, $sformatf("%0d results outstanding, required 0", q4.size()));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  // ---------------- stimulus ----------------
  function automatic exp_t model8(input logic [7:0] a, input logic [7:0] b, input int unsigned n);
    exp_t r;
    r.d  = a - b;
    r.br = (a < b);
    r.n  = n;
    return r;
  endfunction

  function automatic exp_t model4(input logic [3:0] a, input logic [3:0] b, input int unsigned n);
    exp_t r;
    logic [3:0] t;
    t    = a - b;
    r.d  = {4'b0, t};
    r.br = (a < b);
    r.n  = n;
    return r;
  endfunction

  // One op from idle; poke (0..7) re-pulses start with 1/1 operands mid-operation, which must be ignored.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input int poke);
    exp_t x;
    @(negedge clk);
    start8 = 1'b1; a8 = a; b8 = b;
    x = model8(a, b, cyc);
    @(posedge clk);
    q8.push_back(x);
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      start8 = (k == poke && k < 8);
      a8 = 8'($urandom); b8 = 8'($urandom);
      if (k == poke) begin a8 = 8'h01; b8 = 8'h01; end
      @(posedge clk);
    end
  endtask

  task automatic abort8();
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h5A; b8 = 8'h23;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(posedge clk);
  endtask

  // start held high: a new op every WIDTH+2 edges
  task automatic burst8(input int nops);
    exp_t x;
    @(negedge clk);
    start8 = 1'b1;
    for (int i = 0; i < nops; i++) begin
      a8 = 8'($urandom); b8 = 8'($urandom);
      x = model8(a8, b8, cyc);
      @(posedge clk);
      q8.push_back(x);
      repeat (9) @(posedge clk);
      @(negedge clk);
    end
    start8 = 1'b0;
  endtask

  task automatic exhaustive4();
    exp_t x;
    @(negedge clk);
    start4 = 1'b1;
    for (int i = 0; i < 256; i++) begin
      a4 = 4'(i >> 4); b4 = 4'(i);
      x = model4(a4, b4, cyc);
      @(posedge clk);
      q4.push_back(x);
      repeat (5) @(posedge clk);
      @(negedge clk);
    end
    start4 = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0;
    start4 = 1'b0; a4 = '0; b4 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    op8(8'h5A, 8'h23, -1);
    op8(8'h10, 8'h20, -1);
    op8(8'h00, 8'h01, -1);
    op8(8'hFF, 8'hFF, -1);
    op8(8'h5A, 8'h23, 2);
    abort8();
    op8(8'h80, 8'h01, -1);
    for (int i = 0; i < 20; i++)
      op8(8'($urandom), 8'($urandom), ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 7)));
    burst8(10);
    exhaustive4();

    repeat (12) @(posedge clk);
    @(negedge clk);
    end_req = 1'b1;
    repeat (4) @(posedge clk);
    $display("FAIL end_of_test: monitor did not close the run, required summary");
    $fatal(1);
  end

endmodule
